// File: rtl/jk_pkg.sv
// Shared constants for the run-time selectable JK/counter register bank.
package jk_pkg;

  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD   = 3'd0;
  localparam logic [MODE_W-1:0] MODE_JK     = 3'd1;
  localparam logic [MODE_W-1:0] MODE_LOAD   = 3'd2;
  localparam logic [MODE_W-1:0] MODE_TOGGLE = 3'd3;
  localparam logic [MODE_W-1:0] MODE_UP     = 3'd4;
  localparam logic [MODE_W-1:0] MODE_DOWN   = 3'd5;
  localparam logic [MODE_W-1:0] MODE_SHIFT  = 3'd6;

endpackage : jk_pkg

// File: rtl/jk_bit_next.sv
// Combinational next-state cell for one JK flip-flop bit.
module jk_bit_next (
  input  logic q_i,
  input  logic j_i,
  input  logic k_i,
  output logic nq_i
);

  always_comb begin
    nq_i = q_i;
    case ({j_i, k_i})
      2'b00:   nq_i = q_i;
      2'b01:   nq_i = 1'b0;
      2'b10:   nq_i = 1'b1;
      2'b11:   nq_i = ~q_i;
      default: nq_i = q_i;
    endcase
  end

endmodule : jk_bit_next

// File: rtl/jk_mode_register.sv
// WIDTH-bit register bank with run-time selectable JK/load/toggle/count/shift
// next-state logic, a terminal-count flag and a sticky wrap flag.
module jk_mode_register
  import jk_pkg::*;
#(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  j,
  input  logic [WIDTH-1:0]  k,
  input  logic [WIDTH-1:0]  d,
  input  logic              ovf_clr,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  qn,
  output logic              tc,
  output logic              ovf
);

  logic [WIDTH-1:0] r_q;
  logic             r_ovf;
  logic [WIDTH-1:0] w_jk_next;
  logic [WIDTH-1:0] w_shift_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_tc;

  // One JK cell per bit, all fed from the live state.
  for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_jk_bit
    jk_bit_next u_jk_bit_next (
      .q_i  (r_q[gi]),
      .j_i  (j[gi]),
      .k_i  (k[gi]),
      .nq_i (w_jk_next[gi])
    );
  end

  // A single-bit bank simply takes the serial input.
  if (WIDTH == 1) begin : g_shift_w1
    assign w_shift_next = j[0];
  end else begin : g_shift_wn
    assign w_shift_next = {r_q[WIDTH-2:0], j[0]};
  end

  always_comb begin
    w_q_next = r_q;
    case (mode)
      MODE_HOLD:   w_q_next = r_q;
      MODE_JK:     w_q_next = w_jk_next;
      MODE_LOAD:   w_q_next = d;
      MODE_TOGGLE: w_q_next = r_q ^ j;
      MODE_UP:     w_q_next = r_q + WIDTH'(1);
      MODE_DOWN:   w_q_next = r_q - WIDTH'(1);
      MODE_SHIFT:  w_q_next = w_shift_next;
      default:     w_q_next = r_q;
    endcase
  end

  // Asserted whenever the next count step in the current direction wraps.
  assign w_tc = ((mode == MODE_UP)   && (r_q == {WIDTH{1'b1}})) ||
                ((mode == MODE_DOWN) && (r_q == {WIDTH{1'b0}}));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= RESET_VAL;
      r_ovf <= 1'b0;
    end else begin
      if (en) begin
        r_q <= w_q_next;
      end
      // A wrap on the same edge as a clear keeps the flag set.
      if (en && w_tc) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign q   = r_q;
  assign qn  = ~r_q;
  assign tc  = w_tc;
  assign ovf = r_ovf;

endmodule : jk_mode_register
